// File: rtl/jpeg_pixel_capture.sv
// Frame-buffer writer behind jpeg_decode: turns the decoded pixel stream into addressed
// RGB888/RGB565 words and queues them in a small FIFO towards a valid/ready memory port.
module jpeg_pixel_capture #(
  parameter int ADDR_W  = 24,
  parameter int FIFO_AW = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] CfgBase,
  input  logic              CfgMode,
  input  logic              CaptureStart,
  output logic              CaptureBusy,
  output logic              FrameDone,
  output logic              Overflow,
  output logic [31:0]       PixelCount,
  input  logic              InEnable,
  input  logic [15:0]       InWidth,
  input  logic [15:0]       InHeight,
  input  logic [15:0]       InPixelX,
  input  logic [15:0]       InPixelY,
  input  logic [7:0]        InR,
  input  logic [7:0]        InG,
  input  logic [7:0]        InB,
  output logic              MemWrite,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [23:0]       MemData,
  input  logic              MemReady
);

  localparam int                 DEPTH    = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]   CNT_FULL = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0]   CNT_ONE  = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, CAPTURE = 2'd1, DRAIN = 2'd2} state_t;

  state_t              state;
  state_t              next_state;
  logic [ADDR_W-1:0]   base;
  logic                mode;
  logic                stage_valid;
  logic [ADDR_W-1:0]   stage_addr;
  logic [23:0]         stage_data;
  logic [ADDR_W-1:0]   fifo_addr [DEPTH];
  logic [23:0]         fifo_data [DEPTH];
  logic [FIFO_AW-1:0]  wr_ptr;
  logic [FIFO_AW-1:0]  rd_ptr;
  logic [FIFO_AW:0]    count;
  logic [31:0]         product;
  logic [ADDR_W-1:0]   pix_addr;
  logic [23:0]         pix_data;
  logic                start_cap;
  logic                pix_in;
  logic                last_pix;
  logic                full;
  logic                push;
  logic                pop;
  logic                load;
  logic                drop;
  logic                frame_end;

  assign start_cap = (state == IDLE) && CaptureStart;
  assign pix_in    = (state == CAPTURE) && InEnable;
  assign last_pix  = pix_in && (InPixelX == InWidth - 16'd1) && (InPixelY == InHeight - 16'd1);
  assign full      = (count == CNT_FULL);
  assign push      = stage_valid && !full;
  assign pop       = (count != '0) && MemReady;
  // The stage register doubles as one extra slot: it holds its pixel while the FIFO is full,
  // and it is the incoming pixel that gets dropped.
  assign load      = pix_in && (!stage_valid || push);
  assign drop      = pix_in && !load;
  assign frame_end = (state == DRAIN) && !stage_valid &&
                     ((count == '0) || ((count == CNT_ONE) && pop));

  assign MemWrite = (count != '0);
  assign MemAddr  = fifo_addr[rd_ptr];
  assign MemData  = fifo_data[rd_ptr];

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = CaptureStart ? CAPTURE : IDLE;
      CAPTURE: next_state = last_pix ? DRAIN : CAPTURE;
      DRAIN:   next_state = frame_end ? IDLE : DRAIN;
      default: next_state = IDLE;
    endcase
  end

  // Address wraps silently modulo 2**ADDR_W.
  always_comb begin
    product  = 32'(InWidth) * 32'(InPixelY);
    pix_addr = ADDR_W'(product + 32'(InPixelX)) + base;
    pix_data = mode ? {8'h00, InR[7:3], InG[7:2], InB[7:3]} : {InR, InG, InB};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      base        <= '0;
      mode        <= 1'b0;
      CaptureBusy <= 1'b0;
      FrameDone   <= 1'b0;
      Overflow    <= 1'b0;
      PixelCount  <= 32'd0;
    end else begin
      CaptureBusy <= (next_state != IDLE);
      FrameDone   <= frame_end;
      if (start_cap) begin
        base       <= CfgBase;
        mode       <= CfgMode;
        Overflow   <= 1'b0;
        PixelCount <= 32'd0;
      end else begin
        if (drop) Overflow <= 1'b1;
        if (push && (PixelCount != 32'hFFFF_FFFF)) PixelCount <= PixelCount + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage_valid <= 1'b0;
      stage_addr  <= '0;
      stage_data  <= 24'd0;
    end else if (load) begin
      stage_valid <= 1'b1;
      stage_addr  <= pix_addr;
      stage_data  <= pix_data;
    end else if (push) begin
      stage_valid <= 1'b0;
    end
  end

  // Show-ahead FIFO; a push at full is refused even when a pop happens in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_addr[i] <= '0;
        fifo_data[i] <= 24'd0;
      end
    end else begin
      if (push) begin
        fifo_addr[wr_ptr] <= stage_addr;
        fifo_data[wr_ptr] <= stage_data;
        wr_ptr            <= wr_ptr + PTR_ONE;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
      if (push && !pop)      count <= count + CNT_ONE;
      else if (pop && !push) count <= count - CNT_ONE;
    end
  end

endmodule

// File: tb/tb_jpeg_pixel_capture.sv
// Directed bench for jpeg_pixel_capture: frame capture, RGB565 packing, overflow,
// mid-frame reset and address wrap with a 20-bit address bus.
module tb_jpeg_pixel_capture;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [19:0] CfgBase = 20'd0;
  logic        CfgMode = 1'b0;
  logic        CaptureStart = 1'b0;
  logic        CaptureBusy;
  logic        FrameDone;
  logic        Overflow;
  logic [31:0] PixelCount;
  logic        InEnable = 1'b0;
  logic [15:0] InWidth = 16'd0;
  logic [15:0] InHeight = 16'd0;
  logic [15:0] InPixelX = 16'd0;
  logic [15:0] InPixelY = 16'd0;
  logic [7:0]  InR = 8'd0;
  logic [7:0]  InG = 8'd0;
  logic [7:0]  InB = 8'd0;
  logic        MemWrite;
  logic [19:0] MemAddr;
  logic [23:0] MemData;
  logic        MemReady = 1'b1;

  int vectors = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  logic [19:0] wa[$];
  logic [23:0] wd[$];
  int          wc[$];

  jpeg_pixel_capture #(.ADDR_W(20), .FIFO_AW(3)) dut (
    .clk(clk), .rst(rst), .CfgBase(CfgBase), .CfgMode(CfgMode),
    .CaptureStart(CaptureStart), .CaptureBusy(CaptureBusy), .FrameDone(FrameDone),
    .Overflow(Overflow), .PixelCount(PixelCount), .InEnable(InEnable),
    .InWidth(InWidth), .InHeight(InHeight), .InPixelX(InPixelX), .InPixelY(InPixelY),
    .InR(InR), .InG(InG), .InB(InB), .MemWrite(MemWrite), .MemAddr(MemAddr),
    .MemData(MemData), .MemReady(MemReady)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Log accepted writes and frame-done pulses mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (rst && MemWrite && MemReady) begin
      wa.push_back(MemAddr);
      wd.push_back(MemData);
      wc.push_back(cyc);
    end
    if (FrameDone) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pixel(input logic [15:0] x, input logic [15:0] y,
                       input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    InEnable = 1'b1;
    InPixelX = x;
    InPixelY = y;
    InR = r;
    InG = g;
    InB = b;
    tick();
    InEnable = 1'b0;
  endtask

  task automatic start(input logic [19:0] b, input logic m);
    CfgBase = b;
    CfgMode = m;
    CaptureStart = 1'b1;
    tick();
    CaptureStart = 1'b0;
  endtask

  task automatic clear_log();
    wa.delete();
    wd.delete();
    wc.delete();
  endtask

  task automatic wait_done(input int limit);
    int first;
    first = done_cnt;
    for (int i = 0; i < limit && done_cnt == first; i++) tick();
    tick();
    tick();
    check("frame_done_once", 64'(done_cnt - first), 64'd1);
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    check("rst_memwrite", 64'(MemWrite), 64'd0);
    check("rst_busy", 64'(CaptureBusy), 64'd0);
    check("rst_done", 64'(FrameDone), 64'd0);
    check("rst_overflow", 64'(Overflow), 64'd0);
    check("rst_pixcount", 64'(PixelCount), 64'd0);
    check("rst_memaddr", 64'(MemAddr), 64'd0);
    check("rst_memdata", 64'(MemData), 64'd0);
    rst = 1'b1;
    tick();

    // Pixels while idle are ignored
    InWidth = 16'd1;
    InHeight = 16'd1;
    for (int i = 0; i < 3; i++) pixel(16'd0, 16'd0, 8'hAA, 8'hBB, 8'hCC);
    for (int i = 0; i < 4; i++) tick();
    check("idle_memwrite", 64'(MemWrite), 64'd0);
    check("idle_no_writes", 64'(wa.size()), 64'd0);
    check("idle_busy", 64'(CaptureBusy), 64'd0);

    // 4x2 RGB888 at base 0x100, with an ignored CaptureStart mid-frame
    clear_log();
    InWidth = 16'd4;
    InHeight = 16'd2;
    start(20'h00100, 1'b0);
    check("cap_busy", 64'(CaptureBusy), 64'd1);
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        CaptureStart = 1'b1;
        CfgBase = 20'h00200;
        tick();
        CaptureStart = 1'b0;
        check("restart_ignored_count", 64'(PixelCount), 64'd4);
        check("restart_ignored_busy", 64'(CaptureBusy), 64'd1);
      end
      pixel(16'(i % 4), 16'(i / 4), 8'(8'h10 + i), 8'(8'h20 + i), 8'(8'h30 + i));
    end
    wait_done(20);
    check("f1_writes", 64'(wa.size()), 64'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < wa.size()) begin
        check("f1_addr", 64'(wa[i]), 64'(20'h00100 + i));
        check("f1_data", 64'(wd[i]), 64'({8'(8'h10 + i), 8'(8'h20 + i), 8'(8'h30 + i)}));
      end
    end
    if (wc.size() > 0) check("f1_done_after_last", 64'(done_cyc - wc[wc.size() - 1]), 64'd1);
    check("f1_pixcount", 64'(PixelCount), 64'd8);
    check("f1_busy_off", 64'(CaptureBusy), 64'd0);
    check("f1_overflow", 64'(Overflow), 64'd0);

    // RGB565 packing
    clear_log();
    InWidth = 16'd2;
    InHeight = 16'd1;
    start(20'h00000, 1'b1);
    pixel(16'd0, 16'd0, 8'hF8, 8'hFC, 8'hF8);
    pixel(16'd1, 16'd0, 8'h08, 8'h08, 8'h08);
    wait_done(20);
    check("m565_writes", 64'(wa.size()), 64'd2);
    if (wa.size() == 2) begin
      check("m565_addr0", 64'(wa[0]), 64'h0);
      check("m565_data0", 64'(wd[0]), 64'h00FFFF);
      check("m565_addr1", 64'(wa[1]), 64'h1);
      check("m565_data1", 64'(wd[1]), 64'h000841);
    end

    // Overflow: memory stalled, 12 back-to-back pixels into 8 FIFO slots plus the stage
    clear_log();
    InWidth = 16'd12;
    InHeight = 16'd1;
    start(20'h00040, 1'b0);
    MemReady = 1'b0;
    for (int i = 0; i < 12; i++) pixel(16'(i), 16'd0, 8'(8'hA0 + i), 8'(8'h50 + i), 8'(i));
    for (int i = 0; i < 8; i++) tick();
    check("ovf_flag", 64'(Overflow), 64'd1);
    check("ovf_pixcount_stalled", 64'(PixelCount), 64'd8);
    check("ovf_memwrite", 64'(MemWrite), 64'd1);
    check("ovf_head_addr", 64'(MemAddr), 64'h00040);
    check("ovf_head_data", 64'(MemData), 64'hA05000);
    check("ovf_no_accept", 64'(wa.size()), 64'd0);
    MemReady = 1'b1;
    wait_done(30);
    check("ovf_writes", 64'(wa.size()), 64'd9);
    for (int i = 0; i < 9; i++) begin
      if (i < wa.size()) begin
        check("ovf_addr", 64'(wa[i]), 64'(20'h00040 + i));
        check("ovf_data", 64'(wd[i]), 64'({8'(8'hA0 + i), 8'(8'h50 + i), 8'(i)}));
      end
    end
    check("ovf_pixcount", 64'(PixelCount), 64'd9);
    check("ovf_sticky", 64'(Overflow), 64'd1);

    // Reset with 5 entries queued, then a clean capture from the same base
    clear_log();
    InWidth = 16'd8;
    InHeight = 16'd1;
    start(20'h00300, 1'b0);
    check("start_clears_overflow", 64'(Overflow), 64'd0);
    MemReady = 1'b0;
    for (int i = 0; i < 5; i++) pixel(16'(i), 16'd0, 8'hEE, 8'(i), 8'h00);
    for (int i = 0; i < 3; i++) tick();
    check("q5_memwrite", 64'(MemWrite), 64'd1);
    check("q5_pixcount", 64'(PixelCount), 64'd5);
    rst = 1'b0;
    #1;
    check("arst_memwrite", 64'(MemWrite), 64'd0);
    check("arst_busy", 64'(CaptureBusy), 64'd0);
    check("arst_pixcount", 64'(PixelCount), 64'd0);
    tick();
    tick();
    rst = 1'b1;
    MemReady = 1'b1;
    clear_log();
    tick();
    InWidth = 16'd2;
    start(20'h00300, 1'b0);
    pixel(16'd0, 16'd0, 8'h11, 8'h22, 8'h33);
    pixel(16'd1, 16'd0, 8'h44, 8'h55, 8'h66);
    wait_done(20);
    check("post_rst_writes", 64'(wa.size()), 64'd2);
    if (wa.size() == 2) begin
      check("post_rst_addr0", 64'(wa[0]), 64'h00300);
      check("post_rst_data0", 64'(wd[0]), 64'h112233);
      check("post_rst_addr1", 64'(wa[1]), 64'h00301);
      check("post_rst_data1", 64'(wd[1]), 64'h445566);
    end

    // 1920x1080 last pixel, base 0xFFF00: 1920*1079+1919+0xFFF00 = 0x2FA2FF -> 0xFA2FF
    clear_log();
    InWidth = 16'd1920;
    InHeight = 16'd1080;
    start(20'hFFF00, 1'b0);
    pixel(16'd1919, 16'd1079, 8'h12, 8'h34, 8'h56);
    wait_done(20);
    check("wrap_writes", 64'(wa.size()), 64'd1);
    if (wa.size() == 1) begin
      check("wrap_addr", 64'(wa[0]), 64'hFA2FF);
      check("wrap_data", 64'(wd[0]), 64'h123456);
    end
    check("wrap_busy_off", 64'(CaptureBusy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
